// File: rtl/anffl_tex_fetch_arb_if.sv
// Requester, address-generator and memory-port bundle for anffl_tex_fetch_arb.
// Optional perf counters appear only when TEXARB_PERF_EN is defined.
interface anffl_tex_fetch_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*16-1:0]    req_x;
  logic [NUM_REQ*16-1:0]    req_y;
  logic [NUM_REQ*64-1:0]    req_meta;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [15:0]              ag_x;
  logic [15:0]              ag_y;
  logic [63:0]              ag_meta;
  logic [31:0]              ag_address;
  logic [3:0]               ag_xtexel;
  logic [3:0]               ag_ytexel;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [31:0]              mem_addr;
  logic [7:0]               mem_texel;
  logic [3+TAG_W-1:0]       mem_id;
  logic                     mem_rsp_valid;
  logic [7:0]               outstanding;
  logic                     err_underflow;
`ifdef TEXARB_PERF_EN
  logic [31:0]              perf_issued;
  logic [31:0]              perf_stall;
`endif

  modport master (
    input  req_valid, req_x, req_y, req_meta, req_tag,
    input  ag_address, ag_xtexel, ag_ytexel,
    input  mem_ready, mem_rsp_valid,
    output req_ready, ag_x, ag_y, ag_meta,
    output mem_valid, mem_addr, mem_texel, mem_id,
    output outstanding, err_underflow
`ifdef TEXARB_PERF_EN
    , output perf_issued, perf_stall
`endif
  );

  modport slave (
    output req_valid, req_x, req_y, req_meta, req_tag,
    output ag_address, ag_xtexel, ag_ytexel,
    output mem_ready, mem_rsp_valid,
    input  req_ready, ag_x, ag_y, ag_meta,
    input  mem_valid, mem_addr, mem_texel, mem_id,
    input  outstanding, err_underflow
`ifdef TEXARB_PERF_EN
    , input perf_issued, perf_stall
`endif
  );
endinterface

// File: rtl/anffl_tex_fetch_arb.sv
// Round-robin texture fetch arbiter: one addrGen shared, credit-bounded reads.
// Define TEXARB_PERF_EN to add perf_issued/perf_stall counters.
module anffl_tex_fetch_arb #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 8
) (
  input logic clk,
  input logic rst_n,
  anffl_tex_fetch_arb_if.master bus
);
  localparam int IW = 3;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    ISSUE
  } state_e;

  state_e state_q, state_d;

  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [15:0]    ag_x_q, ag_x_d;
  logic [15:0]    ag_y_q, ag_y_d;
  logic [63:0]    ag_meta_q, ag_meta_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [7:0]     mem_texel_q, mem_texel_d;
  logic           mem_valid_q, mem_valid_d;
  logic [7:0]     out_q, out_d;
  logic           err_q, err_d;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW-1:0]        off;
  logic [3:0]           sum;
  logic [IW-1:0]        win;
  logic                 found;
  logic [15:0]          sel_x;
  logic [15:0]          sel_y;
  logic [63:0]          sel_meta;
  logic [TAG_W-1:0]     sel_tag;
  logic                 grant;
  logic                 hs;
  logic                 credit_ok;

  assign credit_ok = out_q < 8'(MAX_OUT);
  assign hs        = mem_valid_q & bus.mem_ready;
  assign grant     = (state_q == IDLE) && found && credit_ok;

  // Rotate valids so bit 0 is rr_ptr+1, then take the first set bit
  always_comb begin
    dbl   = {bus.req_valid, bus.req_valid};
    rot   = NUM_REQ'(dbl >> (rr_ptr_q + 3'd1));
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, rr_ptr_q} + 4'd1 + {1'b0, off};
    if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
    win = sum[IW-1:0];
  end

  // Mux out the winner's pixel, meta and tag
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_meta = '0;
    sel_tag  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == IW'(k)) begin
        sel_x    = bus.req_x[16*k +: 16];
        sel_y    = bus.req_y[16*k +: 16];
        sel_meta = bus.req_meta[64*k +: 64];
        sel_tag  = bus.req_tag[TAG_W*k +: TAG_W];
      end
    end
  end

  // FSM next state: latch request, capture addrGen result, hold read until accepted
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    ag_x_d      = ag_x_q;
    ag_y_d      = ag_y_q;
    ag_meta_d   = ag_meta_q;
    tag_d       = tag_q;
    mem_addr_d  = mem_addr_q;
    mem_texel_d = mem_texel_q;
    mem_valid_d = mem_valid_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = ADDR;
          rr_ptr_d  = win;
          idx_d     = win;
          ag_x_d    = sel_x;
          ag_y_d    = sel_y;
          ag_meta_d = sel_meta;
          tag_d     = sel_tag;
        end
      end
      ADDR: begin
        mem_addr_d  = bus.ag_address;
        mem_texel_d = {bus.ag_ytexel, bus.ag_xtexel};
        mem_valid_d = 1'b1;
        state_d     = ISSUE;
      end
      ISSUE: begin
        if (hs) begin
          mem_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter; a retire with nothing in flight is flagged, not counted
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (bus.mem_rsp_valid && out_q == 8'd0) err_d = 1'b1;
    if (hs && !bus.mem_rsp_valid) begin
      out_d = out_q + 8'd1;
    end else if (!hs && bus.mem_rsp_valid && out_q != 8'd0) begin
      out_d = out_q - 8'd1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IW'(NUM_REQ - 1);
      idx_q       <= '0;
      ag_x_q      <= '0;
      ag_y_q      <= '0;
      ag_meta_q   <= '0;
      tag_q       <= '0;
      mem_addr_q  <= '0;
      mem_texel_q <= '0;
      mem_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      ag_x_q      <= ag_x_d;
      ag_y_q      <= ag_y_d;
      ag_meta_q   <= ag_meta_d;
      tag_q       <= tag_d;
      mem_addr_q  <= mem_addr_d;
      mem_texel_q <= mem_texel_d;
      mem_valid_q <= mem_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready     = grant ? (NUM_REQ'(1) << win) : '0;
  assign bus.ag_x          = ag_x_q;
  assign bus.ag_y          = ag_y_q;
  assign bus.ag_meta       = ag_meta_q;
  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_texel     = mem_texel_q;
  assign bus.mem_id        = {idx_q, tag_q};
  assign bus.outstanding   = out_q;
  assign bus.err_underflow = err_q;

`ifdef TEXARB_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Handshake and stall counters, free-running with wrap
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (hs) perf_issued_d = perf_issued_q + 32'd1;
    if (mem_valid_q && !bus.mem_ready) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign bus.perf_issued = perf_issued_q;
  assign bus.perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_anffl_tex_fetch_arb.sv
// Bench for anffl_tex_fetch_arb: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_anffl_tex_fetch_arb;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 4;
  localparam int MAX_OUT = 2;

  logic clk;
  logic rst_n;

  anffl_tex_fetch_arb_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  anffl_tex_fetch_arb #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] agen(logic [15:0] x, logic [15:0] y,
                                       logic [63:0] meta);
    logic [31:0] base;
    logic [3:0]  wexp;
    base = meta[63:32];
    wexp = meta[12:9];
    return base + (((32'(y) << wexp) + 32'(x)) << 2);
  endfunction

  always_comb begin
    bus.ag_address = agen(bus.ag_x, bus.ag_y, bus.ag_meta);
    bus.ag_xtexel  = bus.ag_x[3:0];
    bus.ag_ytexel  = bus.ag_y[3:0];
  end

  int n_chk;
  int n_err;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int          m_ptr;
  bit          m_busy;
  int          m_issue_at;
  int          cyc;
  int          m_cnt;
  bit          m_err;
  logic [31:0] e_addr;
  logic [7:0]  e_tex;
  logic [6:0]  e_id;
  logic [31:0] m_issued;
  logic [31:0] m_stall;
  int          g_log[$];

  task automatic model_reset();
    m_ptr      = NUM_REQ - 1;
    m_busy     = 0;
    m_issue_at = 0;
    m_cnt      = 0;
    m_err      = 0;
    m_issued   = 0;
    m_stall    = 0;
    cyc        = 0;
  endtask

  task automatic model_cycle();
    int w;
    logic [NUM_REQ-1:0] er;
    logic [NUM_REQ-1:0] v;
    bit mv;
    bit hs;
    logic [15:0] xx;
    logic [15:0] yy;
    logic [63:0] mm;
    logic [TAG_W-1:0] tg;
    w = -1;
    if (!m_busy && m_cnt < MAX_OUT) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        int j;
        j = (m_ptr + i) % NUM_REQ;
        v = bus.req_valid >> j;
        if (w < 0 && v[0]) w = j;
      end
    end
    er = '0;
    if (w >= 0) er = NUM_REQ'(1) << w;
    check("req_ready", 64'(bus.req_ready), 64'(er));
    mv = m_busy && (cyc >= m_issue_at);
    check("mem_valid", 64'(bus.mem_valid), 64'(mv));
    if (mv) begin
      check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      check("mem_texel", 64'(bus.mem_texel), 64'(e_tex));
      check("mem_id", 64'(bus.mem_id), 64'(e_id));
    end
    check("outstanding", 64'(bus.outstanding), 64'(m_cnt));
    check("err_underflow", 64'(bus.err_underflow), 64'(m_err));
`ifdef TEXARB_PERF_EN
    check("perf_issued", 64'(bus.perf_issued), 64'(m_issued));
    check("perf_stall", 64'(bus.perf_stall), 64'(m_stall));
`endif
    hs = mv && bus.mem_ready;
    if (hs) m_issued = m_issued + 1;
    if (mv && !bus.mem_ready) m_stall = m_stall + 1;
    if (bus.mem_rsp_valid && m_cnt == 0) m_err = 1;
    if (hs && !bus.mem_rsp_valid) m_cnt++;
    else if (!hs && bus.mem_rsp_valid && m_cnt > 0) m_cnt--;
    if (hs) m_busy = 0;
    if (w >= 0) begin
      xx = 16'(bus.req_x >> (16 * w));
      yy = 16'(bus.req_y >> (16 * w));
      mm = 64'(bus.req_meta >> (64 * w));
      tg = TAG_W'(bus.req_tag >> (TAG_W * w));
      e_addr     = agen(xx, yy, mm);
      e_tex      = {yy[3:0], xx[3:0]};
      e_id       = {3'(w), tg};
      m_busy     = 1;
      m_ptr      = w;
      m_issue_at = cyc + 2;
      g_log.push_back(w);
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_x[16*i +: 16]       = 16'($urandom);
      bus.req_y[16*i +: 16]       = 16'($urandom);
      bus.req_meta[64*i +: 64]    = {32'($urandom), 32'($urandom)};
      bus.req_tag[TAG_W*i +: TAG_W] = TAG_W'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.req_valid     = '0;
    bus.mem_ready     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    #1;
    model_reset();
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_outstanding", 64'(bus.outstanding), 64'd0);
    check("rst_err", 64'(bus.err_underflow), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_id", 64'(bus.mem_id), 64'd0);
    check("rst_ag_x", 64'(bus.ag_x), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20 && (m_busy || m_cnt > 0); i++) begin
      bus.mem_rsp_valid = (m_cnt > 0);
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    check("drain_outstanding", 64'(bus.outstanding), 64'd0);
  endtask

  task automatic wait_mem_valid(string tag);
    for (int i = 0; i < 10 && !bus.mem_valid; i++) begin
      step();
      bus.req_valid = '0;
    end
    check(tag, 64'(bus.mem_valid), 64'd1);
  endtask

  initial begin
    int g0;
`ifdef TEXARB_PERF_EN
    logic [31:0] st0;
`endif
    n_chk = 0;
    n_err = 0;
    bus.req_x    = '0;
    bus.req_y    = '0;
    bus.req_meta = '0;
    bus.req_tag  = '0;
    apply_reset();

    // round-robin order with all requesters busy
    g_log.delete();
    bus.req_valid = '1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      bus.mem_rsp_valid = (m_cnt > 0);
      step();
    end
    check("rr_count", 64'(g_log.size() >= 5), 64'd1);
    if (g_log.size() >= 5) begin
      check("rr_g0", 64'(g_log[0]), 64'd0);
      check("rr_g1", 64'(g_log[1]), 64'd1);
      check("rr_g2", 64'(g_log[2]), 64'd2);
      check("rr_g3", 64'(g_log[3]), 64'd3);
      check("rr_g4", 64'(g_log[4]), 64'd0);
    end
    drain();

    // address path through requester 2
    bus.req_x[32 +: 16]    = 16'd5;
    bus.req_y[32 +: 16]    = 16'd3;
    bus.req_meta[128 +: 64] = {32'h1000_0000, 19'b0, 4'd4, 4'd4, 5'b00100};
    bus.req_tag[8 +: 4]    = 4'hA;
    bus.req_valid          = 4'b0100;
    wait_mem_valid("addr_mv");
    check("addr_val", 64'(bus.mem_addr), 64'h1000_00D4);
    check("addr_id", 64'(bus.mem_id), 64'h2A);
    step();
    drain();

    // backpressure: five stall cycles then one handshake
    rand_data();
    bus.mem_ready = 1'b0;
    bus.req_valid = 4'b0001;
    wait_mem_valid("bp_mv");
`ifdef TEXARB_PERF_EN
    st0 = m_stall;
`endif
    g0 = int'(m_issued);
    for (int i = 0; i < 5; i++) step();
    bus.mem_ready = 1'b1;
    step();
    check("bp_done", 64'(bus.mem_valid), 64'd0);
    check("bp_one_hs", 64'(int'(m_issued) - g0), 64'd1);
`ifdef TEXARB_PERF_EN
    check("bp_stall", 64'(bus.perf_stall), 64'(st0 + 32'd5));
`endif
    drain();

    // credit exhaustion, release and simultaneous retire+issue
    g_log.delete();
    bus.req_valid = '1;
    for (int i = 0; i < 12; i++) begin
      rand_data();
      step();
    end
    check("cr_issues", 64'(g_log.size()), 64'd2);
    check("cr_out", 64'(bus.outstanding), 64'd2);
    check("cr_blocked", 64'(bus.req_ready), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    for (int i = 0; i < 4 && g_log.size() < 3; i++) step();
    check("cr_regrant", 64'(g_log.size()), 64'd3);
    bus.req_valid = '0;
    wait_mem_valid("cr_mv");
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    check("cr_same", 64'(bus.outstanding), 64'd1);
    drain();

    // underflow is sticky with the counter pinned at zero
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    step();
    check("uf_err", 64'(bus.err_underflow), 64'd1);
    check("uf_out", 64'(bus.outstanding), 64'd0);

    // reset while a read is pending
    bus.mem_ready = 1'b0;
    bus.req_valid = 4'b0010;
    wait_mem_valid("mid_mv");
    apply_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      rand_data();
      bus.req_valid = NUM_REQ'($urandom);
      bus.mem_ready = ($urandom % 4) != 0;
      if (m_cnt > 0) bus.mem_rsp_valid = ($urandom % 3) == 0;
      else bus.mem_rsp_valid = ($urandom % 50) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
